// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO read-side stream adapter.
// Occupancy is modelled as an enum so the skid buffer reads as a small state machine.
package fifo_pkg;

  localparam int BUF_DEPTH = 3;
  localparam int PTR_W     = 2;
  localparam int OCC_W     = 2;

  typedef enum logic [OCC_W-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2,
    OCC_FULL  = 2'd3
  } occ_t;

  typedef logic [PTR_W-1:0] ptr_t;

  // Pointers wrap at the buffer depth rather than at the natural 2-bit limit.
  function automatic ptr_t ptr_next(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // True when a new pop cannot overrun the buffer once the in-flight word lands.
  function automatic logic room_for_pop(input occ_t occ, input logic inflight);
    return ({1'b0, occ} + {2'b00, inflight}) < 3'(BUF_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Three-entry circular buffer that absorbs the FIFO read latency.
// Occupancy follows EMPTY/ONE/TWO/FULL: +1 on push, -1 on pop, EMPTY on clear.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  input  logic              clear,
  output logic [OCC_W-1:0]  occ,
  output logic [DWIDTH-1:0] head_data
);

  logic [DWIDTH-1:0] mem [BUF_DEPTH];
  ptr_t              rp;
  ptr_t              wp;
  occ_t              occ_q;
  logic              push_ok;
  logic              pop_ok;

  // Guard against protocol misuse so occupancy can never leave 0..3.
  assign pop_ok  = pop && (occ_q != OCC_EMPTY);
  assign push_ok = push && ((occ_q != OCC_FULL) || pop_ok);

  // NOTE: storage is reset because the head word drives m_data, which must read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_ok && !clear) begin
      mem[wp] <= push_data;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rp    <= '0;
      wp    <= '0;
      occ_q <= OCC_EMPTY;
    end else if (clear) begin
      rp    <= '0;
      wp    <= '0;
      occ_q <= OCC_EMPTY;
    end else begin
      if (push_ok) wp <= ptr_next(wp);
      if (pop_ok)  rp <= ptr_next(rp);
      unique case (occ_q)
        OCC_EMPTY: if (push_ok) occ_q <= OCC_ONE;
        OCC_ONE: begin
          if (push_ok && !pop_ok)      occ_q <= OCC_TWO;
          else if (pop_ok && !push_ok) occ_q <= OCC_EMPTY;
        end
        OCC_TWO: begin
          if (push_ok && !pop_ok)      occ_q <= OCC_FULL;
          else if (pop_ok && !push_ok) occ_q <= OCC_ONE;
        end
        OCC_FULL: if (pop_ok && !push_ok) occ_q <= OCC_TWO;
      endcase
    end
  end

  assign occ       = occ_q;
  assign head_data = mem[rp];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: pops the synchronous FIFO and presents its words as a valid/ready stream.
// Optional handshake counter on xfer_count is enabled by defining FIFO_RD_STATS_EN.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DWIDTH-1:0] fifo_data,
  input  logic              flush,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [CWIDTH-1:0] xfer_count
`endif
);

  logic             inflight;
  logic [OCC_W-1:0] occ;
  occ_t             occ_s;
  logic             push;
  logic             xfer;

  assign occ_s = occ_t'(occ);

  // Pop decision uses only registered state, so no path exists from m_ready.
  assign fifo_rd_en = !rst && !fifo_empty && !flush && room_for_pop(occ_s, inflight);

  // No pop is issued during a flush, so the only word that can arrive then is the one
  // popped just before it; gating capture with flush drops exactly that word.
  assign push = inflight && !flush;

  assign m_valid = (occ_s != OCC_EMPTY);
  assign xfer    = m_valid && m_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight <= 1'b0;
    else     inflight <= fifo_rd_en;
  end

  fifo_rd_skid_buf #(
    .DWIDTH (DWIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_data),
    .pop       (xfer),
    .clear     (flush),
    .occ       (occ),
    .head_data (m_data)
  );

`ifdef FIFO_RD_STATS_EN
  // Flush does not clear the count; a handshake in the flush cycle still counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       xfer_count <= '0;
    else if (xfer) xfer_count <= xfer_count + CWIDTH'(1);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream with a behavioural one-cycle-latency FIFO.
// Counter checks run only when FIFO_RD_STATS_EN is defined (CWIDTH = 4 to exercise wrap).
module tb_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STATS_EN
  logic [CW-1:0] xfer_count;
`endif

  fifo_rd_stream #(
    .DWIDTH (DW),
    .CWIDTH (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RD_STATS_EN
    ,
    .xfer_count (xfer_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural FIFO: words are appended by stimulus, popped with one-cycle read latency.
  logic [DW-1:0] fifo_mem [$];
  int            n_loaded = 0;
  int            n_popped = 0;
  logic          force_ne = 1'b0;

  assign fifo_empty = !force_ne && (n_loaded == n_popped);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_data <= '0;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_data <= fifo_mem[n_popped];
      n_popped  <= n_popped + 1;
    end
  end

  logic [DW-1:0] exp_q [$];

  task automatic load(input logic [DW-1:0] w, input bit expect_out);
    fifo_mem.push_back(w);
    n_loaded++;
    if (expect_out) exp_q.push_back(w);
  endtask

  // Monitor: scoreboard compare on every handshake, plus hold-stability under back-pressure.
  int            rd_cnt = 0;
  logic          prev_valid = 1'b0;
  logic          prev_ready = 1'b0;
  logic          prev_flush = 1'b0;
  logic [DW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_unexpected: got 0x%0h expected no word at %0t", m_data, $time);
        end else begin
          check("stream_data", {24'h0, m_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (prev_valid && !prev_ready && !prev_flush) begin
        check("hold_valid", {31'h0, m_valid}, 32'h1);
        check("hold_data", {24'h0, m_data}, {24'h0, prev_data});
      end
      if (fifo_rd_en) rd_cnt++;
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_flush = flush;
      prev_data  = m_data;
    end
  end

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    m_ready  = 1'b0;
    force_ne = 1'b1;

    // Reset with a non-empty FIFO: nothing may be popped or presented.
    repeat (2) @(negedge clk);
    check("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    check("rst_m_valid", {31'h0, m_valid}, 32'h0);
    check("rst_m_data", {24'h0, m_data}, 32'h0);
`ifdef FIFO_RD_STATS_EN
    check("rst_xfer_count", {28'h0, xfer_count}, 32'h0);
`endif
    @(posedge clk); #1;
    force_ne = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;

    // Single word: pop once, valid two edges after the pop, gone after the handshake.
    m_ready = 1'b1;
    load(8'hA5, 1'b1);
    @(negedge clk);
    check("single_pop", {31'h0, fifo_rd_en}, 32'h1);
    check("single_nvalid0", {31'h0, m_valid}, 32'h0);
    @(negedge clk);
    check("single_no_pop", {31'h0, fifo_rd_en}, 32'h0);
    check("single_nvalid1", {31'h0, m_valid}, 32'h0);
    @(negedge clk);
    check("single_valid", {31'h0, m_valid}, 32'h1);
    check("single_data", {24'h0, m_data}, 32'hA5);
    @(negedge clk);
    check("single_drop", {31'h0, m_valid}, 32'h0);

    // Streaming: 16 words back-to-back with m_ready held high.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) load(DW'(i), 1'b1);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("stream_valid_%0d", i), {31'h0, m_valid}, 32'h1);
    end
    @(negedge clk);
    check("stream_end", {31'h0, m_valid}, 32'h0);
`ifdef FIFO_RD_STATS_EN
    check("count_wrap", {28'h0, xfer_count}, 32'd1);
`endif

    // Back-pressure: only 3 pops, head word held, then everything drains in order.
    @(posedge clk); #1;
    m_ready = 1'b0;
    rd_cnt  = 0;
    for (int i = 0; i < 8; i++) load(8'h80 + DW'(i), 1'b1);
    repeat (10) @(negedge clk);
    check("bp_pops", rd_cnt, 3);
    check("bp_rd_en_low", {31'h0, fifo_rd_en}, 32'h0);
    check("bp_valid", {31'h0, m_valid}, 32'h1);
    check("bp_head", {24'h0, m_data}, 32'h80);
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain("bp_drain");
`ifdef FIFO_RD_STATS_EN
    check("count_bp", {28'h0, xfer_count}, 32'd9);
`endif

    // Flush while 0x33 is in flight: 0x11/0x22 discarded, 0x33 dropped, 0x44 first out.
    @(posedge clk); #1;
    m_ready = 1'b0;
    load(8'h11, 1'b0);
    load(8'h22, 1'b0);
    load(8'h33, 1'b0);
    load(8'h44, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_pre_valid", {31'h0, m_valid}, 32'h1);
    check("flush_pre_data", {24'h0, m_data}, 32'h11);
    check("flush_no_pop", {31'h0, fifo_rd_en}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_valid_low", {31'h0, m_valid}, 32'h0);
    check("flush_repop", {31'h0, fifo_rd_en}, 32'h1);
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain("flush_drain");
`ifdef FIFO_RD_STATS_EN
    check("count_flush", {28'h0, xfer_count}, 32'd10);
`endif

    repeat (3) @(negedge clk);
    check("final_scoreboard", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

- Read-side adapter for the team's synchronous FIFO.
- Drives the FIFO's `rd_en`/`empty`/`data_out` pop interface, absorbs its one-cycle read latency, and presents the words as a valid/ready stream.
- Sits between a FIFO instance and any downstream consumer.
- Sustains one word per cycle, and `fifo_rd_en` has no combinational path from `m_ready`.

## Interface
Parameters:
- `DWIDTH`, default 8: data word width; must match the attached FIFO.
- `CWIDTH`, default 16: width of the transfer counter (used only with `FIFO_RD_STATS_EN`).

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop request to the FIFO.
- `fifo_data`  in  DWIDTH  FIFO `data_out`; valid the cycle after an accepted pop.
- `flush`  in  1  synchronous discard of all buffered and in-flight words.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  consumer accepts the word.
- `m_data`  out  DWIDTH  stream word.
- `xfer_count`  out  CWIDTH  count of completed handshakes (present only with `FIFO_RD_STATS_EN`).

## Operation
- **Internal buffer:** 3-entry circular buffer.
  - `occ` is 0..3; read pointer `rp` and write pointer `wp` are each 2 bits and wrap 2->0.
- **Tracking the pop:** `inflight` is a register equal to the previous cycle's `fifo_rd_en`.
- **Pop rule:** `fifo_rd_en = !rst && !fifo_empty && !flush && (occ + inflight < 3)`.
  - This depends only on registered state, `fifo_empty` and `flush`.
- **Capture:** when `inflight` is 1 and no discard is pending, `fifo_data` is written at `wp`, `wp` increments and `occ` increments.
- **Output:** `m_valid = (occ != 0)` and `m_data = buf[rp]`, both from registered state.
- **Handshake:** on `m_valid && m_ready`, `rp` increments and `occ` decrements.
  - Capture and handshake in the same cycle leave `occ` unchanged.
- **Stream rules:**
  - Once `m_valid` is asserted, `m_valid` and `m_data` stay stable until the handshake or a flush.
  - `m_ready` may toggle freely.
- **Flush:**
  - The next edge sets `occ`, `rp` and `wp` to 0.
  - If a pop is in flight (`inflight` = 1), that word is dropped on arrival.
  - `fifo_rd_en` is 0 during the flush cycle.
  - A handshake in the flush cycle still counts as a completed transfer.
- **Occupancy states:** EMPTY (0), ONE, TWO, FULL (3). Transitions follow +1 for capture, -1 for handshake, to EMPTY on flush.
  - `occ` never exceeds 3, guaranteed by the pop rule.

## Timing
- **Reset values:**
  - `m_valid` 0, `m_data` 0 (the buffer is reset to 0).
  - `fifo_rd_en` 0 while `rst` is high.
  - `occ`, `rp`, `wp`, `inflight` 0; `xfer_count` 0.
- **Latency:** first `fifo_rd_en` to `m_valid` is 2 edges.
  - Pop at edge N; data captured at edge N+1; `m_valid` is high after edge N+1.
- **Throughput:** one word per cycle whenever the FIFO is non-empty and `m_ready` is held high.
- **Back-pressure:** with `m_ready` low, at most 3 words are popped; `fifo_rd_en` then stays low.
- **Reset mid-operation:**
  - Buffered and in-flight words are lost.
  - The FIFO state is the caller's responsibility; the FIFO shares `rst`.

## Configuration
- **`FIFO_RD_STATS_EN` defined:**
  - A `CWIDTH`-bit `xfer_count` increments on each `m_valid && m_ready` and wraps from all-ones to 0.
  - `flush` does not clear it; reset does.
- **`FIFO_RD_STATS_EN` undefined:** the `xfer_count` port and counter logic are absent; everything else is identical.

## Structure
- **Package `fifo_pkg`:**
  - `BUF_DEPTH = 3`
  - `PTR_W = 2`
  - `OCC_W = 2`
  - typedef `occ_t` (occupancy 0..3)
  - typedef `ptr_t`
- **Sub-module `fifo_rd_skid_buf`:**
  - Contents: 3-entry storage, pointers and `occ`.
  - Inputs: `push`, `pop`, `clear`.
  - Outputs: `occ`, head data.
- **Top level:** pop rule, `inflight`/discard tracking and the stats counter.

## Test plan
- **Reset:** `rst` high with `fifo_empty` = 0 -> `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0x00, `xfer_count` = 0.
- **Single word:** FIFO holds 0xA5, `m_ready` = 1.
  - `fifo_rd_en` pulses once.
  - `m_valid` with `m_data` = 0xA5 appears 2 edges after the pop and drops after the handshake.
- **Streaming:** 16 words 0x00..0x0F, `m_ready` held at 1 -> 16 consecutive valid cycles in order; `xfer_count` = 16.
- **Back-pressure:** 8 words queued, `m_ready` = 0 for 10 cycles.
  - Exactly 3 pops occur, then `fifo_rd_en` = 0.
  - `m_data` holds the first word throughout.
  - On release, all 8 words arrive in order.
- **Flush with pop in flight:** buffer holds 0x11, 0x22; `flush` is asserted in the cycle after a pop of 0x33.
  - `m_valid` = 0 the next cycle.
  - 0x33 is never presented.
  - The next FIFO word 0x44 is the first word out.
- **Counter wrap:** `CWIDTH` = 4, 17 handshakes -> `xfer_count` = 1.
